// File: rtl/pipelined_datapath_v2.sv
// Four-stage in-order integer pipeline (Fetch, Decode/RegRead, Execute, Writeback)
// with fetch stall handshake, optional E/W bypass, interlocks and branch flush.
module pipelined_datapath_v2 #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0]  BOOT_ADDRESS = 'h1000,
  parameter bit                       FORWARDING   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic [31:0]             imem_data,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [31:0]             retired_count,
  output logic [31:0]             stall_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;

  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic                    fd_valid_q, fd_valid_d;
  logic [31:0]             fd_instr_q, fd_instr_d;
  logic [ADDRESS_SIZE-1:0] fd_pc_q, fd_pc_d;

  logic                    de_valid_q, de_we_q;
  logic [3:0]              de_op_q;
  logic [4:0]              de_rd_q;
  logic [DATA_WIDTH-1:0]   de_a_q, de_b_q;
  logic [12:0]             de_imm_q;
  logic [ADDRESS_SIZE-1:0] de_pc_q;

  logic                    ew_valid_q, ew_we_q;
  logic [4:0]              ew_rd_q;
  logic [DATA_WIDTH-1:0]   ew_data_q;

  logic [31:0]             retired_q, stall_q;
  logic [DATA_WIDTH-1:0]   rf_q [32];

  // Decode field extraction
  logic [3:0]            d_op;
  logic [4:0]            d_rd;
  logic [4:0]            d_rs [2];
  logic [1:0]            d_use, e_hit, w_hit;
  logic                  d_we, d_hazard, stall;
  logic [DATA_WIDTH-1:0] d_opnd [2];

  assign d_op    = fd_instr_q[31:28];
  assign d_rd    = fd_instr_q[27:23];
  assign d_rs[0] = fd_instr_q[22:18];
  assign d_rs[1] = fd_instr_q[17:13];
  assign d_use[0] = (d_op <= OP_BEQ);
  assign d_use[1] = (d_op <= OP_BEQ) && (d_op != OP_ADDI);
  assign d_we     = (d_op <= OP_OR);

  // Execute
  logic [DATA_WIDTH-1:0]   e_imm, e_result;
  logic [ADDRESS_SIZE-1:0] e_target;
  logic                    e_taken;

  assign e_imm    = {{(DATA_WIDTH-13){de_imm_q[12]}}, de_imm_q};
  assign e_target = de_pc_q + ({{(ADDRESS_SIZE-13){de_imm_q[12]}}, de_imm_q} << 2);
  assign e_taken  = de_valid_q && (de_op_q == OP_BEQ) && (de_a_q == de_b_q);

  always_comb begin
    e_result = '0;
    case (de_op_q)
      OP_ADD:  e_result = de_a_q + de_b_q;
      OP_SUB:  e_result = de_a_q - de_b_q;
      OP_ADDI: e_result = de_a_q + e_imm;
      OP_AND:  e_result = de_a_q & de_b_q;
      OP_OR:   e_result = de_a_q | de_b_q;
      default: e_result = '0;
    endcase
  end

  // Per-source hazard detection and operand selection; r0 never matches
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign e_hit[gi] = de_valid_q && de_we_q && (de_rd_q == d_rs[gi]) && (d_rs[gi] != 5'd0);
    assign w_hit[gi] = ew_valid_q && ew_we_q && (ew_rd_q == d_rs[gi]) && (d_rs[gi] != 5'd0);
    if (FORWARDING) begin : g_fwd
      assign d_opnd[gi] = e_hit[gi] ? e_result :
                          w_hit[gi] ? ew_data_q : rf_q[d_rs[gi]];
    end else begin : g_nofwd
      assign d_opnd[gi] = rf_q[d_rs[gi]];
    end
  end

  assign d_hazard = fd_valid_q && (|(d_use & (e_hit | w_hit)));
  assign stall    = !FORWARDING && d_hazard && !e_taken;

  always_comb begin
    pc_d       = pc_q;
    fd_valid_d = fd_valid_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    if (e_taken) begin
      pc_d       = e_target;
      fd_valid_d = 1'b0;
    end else if (!stall) begin
      if (imem_ready) begin
        fd_valid_d = 1'b1;
        fd_instr_d = imem_data;
        fd_pc_d    = pc_q;
        pc_d       = pc_q + ADDRESS_SIZE'(4);
      end else begin
        fd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= BOOT_ADDRESS;
      fd_valid_q <= 1'b0;
      fd_instr_q <= '0;
      fd_pc_q    <= '0;
      de_valid_q <= 1'b0;
      de_we_q    <= 1'b0;
      de_op_q    <= '0;
      de_rd_q    <= '0;
      de_a_q     <= '0;
      de_b_q     <= '0;
      de_imm_q   <= '0;
      de_pc_q    <= '0;
      ew_valid_q <= 1'b0;
      ew_we_q    <= 1'b0;
      ew_rd_q    <= '0;
      ew_data_q  <= '0;
      retired_q  <= '0;
      stall_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      fd_valid_q <= fd_valid_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      de_valid_q <= fd_valid_q && !stall && !e_taken;
      de_we_q    <= d_we;
      de_op_q    <= d_op;
      de_rd_q    <= d_rd;
      de_a_q     <= d_opnd[0];
      de_b_q     <= d_opnd[1];
      de_imm_q   <= fd_instr_q[12:0];
      de_pc_q    <= fd_pc_q;
      ew_valid_q <= de_valid_q;
      // Bubbles leave rd/data untouched so the retire port holds its last value
      if (de_valid_q) begin
        ew_we_q   <= de_we_q;
        ew_rd_q   <= de_rd_q;
        ew_data_q <= e_result;
      end
      if (ew_valid_q) retired_q <= retired_q + 32'd1;
      if (stall)      stall_q   <= stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (ew_valid_q && ew_we_q && (ew_rd_q != 5'd0)) begin
      rf_q[ew_rd_q] <= ew_data_q;
    end
  end

  assign imem_addr     = pc_q;
  assign wb_valid      = ew_valid_q;
  assign wb_rd         = ew_rd_q;
  assign wb_data       = ew_data_q;
  assign retired_count = retired_q;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_pipelined_datapath_v2.sv
// Directed bench: instance 0 is stall-only (FORWARDING=0), instance 1 bypasses.
module tb_pipelined_datapath_v2;

  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ready;
  logic [31:0] imem_addr [2];
  logic [31:0] imem_data [2];
  logic [31:0] idx [2];
  logic        wb_valid [2];
  logic [4:0]  wb_rd [2];
  logic [31:0] wb_data [2];
  logic [31:0] retired_count [2];
  logic [31:0] stall_count [2];

  logic [31:0] prog [16];
  int          cyc = 0;
  int          rdy_lo = 0, rdy_hi = 0;
  int          total = 0, bad = 0;

  logic [31:0] a_log [2][64];
  logic        v_log [2][64];
  logic [4:0]  r_log [2][64];
  logic [31:0] d_log [2][64];

  always #5 clk = ~clk;

  pipelined_datapath_v2 #(.FORWARDING(1'b0)) u_nofwd (
    .clk(clk), .reset(reset), .imem_addr(imem_addr[0]), .imem_ready(imem_ready),
    .imem_data(imem_data[0]), .wb_valid(wb_valid[0]), .wb_rd(wb_rd[0]), .wb_data(wb_data[0]),
    .retired_count(retired_count[0]), .stall_count(stall_count[0]));

  pipelined_datapath_v2 #(.FORWARDING(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .imem_addr(imem_addr[1]), .imem_ready(imem_ready),
    .imem_data(imem_data[1]), .wb_valid(wb_valid[1]), .wb_rd(wb_rd[1]), .wb_data(wb_data[1]),
    .retired_count(retired_count[1]), .stall_count(stall_count[1]));

  assign idx[0] = (imem_addr[0] - 32'h1000) >> 2;
  assign idx[1] = (imem_addr[1] - 32'h1000) >> 2;
  assign imem_data[0] = (idx[0] < 32'd16) ? prog[idx[0][3:0]] : NOP;
  assign imem_data[1] = (idx[1] < 32'd16) ? prog[idx[1][3:0]] : NOP;
  assign imem_ready = !((cyc >= rdy_lo) && (cyc < rdy_hi));

  // Cycle k runs from posedge k-1 to posedge k; each cycle is logged at its negedge
  always @(negedge clk) begin
    if (!reset) begin
      cyc <= 0;
      for (int u = 0; u < 2; u++)
        for (int k = 0; k < 64; k++) begin
          a_log[u][k] <= '0; v_log[u][k] <= 1'b0; r_log[u][k] <= '0; d_log[u][k] <= '0;
        end
    end else begin
      cyc <= cyc + 1;
      if (cyc < 63)
        for (int u = 0; u < 2; u++) begin
          a_log[u][cyc+1] <= imem_addr[u];
          v_log[u][cyc+1] <= wb_valid[u];
          r_log[u][cyc+1] <= wb_rd[u];
          d_log[u][cyc+1] <= wb_data[u];
        end
    end
  end

  function automatic logic [31:0] ins(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] o, d, s1, s2, im;
    o = op; d = rd; s1 = rs1; s2 = rs2; im = imm;
    return {o[3:0], d[4:0], s1[4:0], s2[4:0], im[12:0]};
  endfunction

  task automatic load_nops();
    for (int k = 0; k < 16; k++) prog[k] = NOP;
  endtask

  task automatic start();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    load_nops();
    rdy_lo = 0; rdy_hi = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (imem_addr[u] !== 32'h1000 || wb_valid[u] !== 1'b0 || wb_rd[u] !== 5'd0 ||
          wb_data[u] !== 32'd0 || retired_count[u] !== 32'd0 || stall_count[u] !== 32'd0) begin
        bad++;
        $display("FAIL reset_state[%0d]: addr=%h v=%b rd=%0d data=%h ret=%0d stl=%0d, want 1000/0/0/0/0/0",
                 u, imem_addr[u], wb_valid[u], wb_rd[u], wb_data[u], retired_count[u], stall_count[u]);
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    run(6);
    for (int u = 0; u < 2; u++) begin
      for (int k = 1; k <= 3; k++) begin
        total++;
        if (a_log[u][k] !== 32'h1000 + 32'(4 * (k - 1))) begin
          bad++;
          $display("FAIL boot_fetch[%0d] cyc%0d: got %h want %h", u, k, a_log[u][k], 32'h1000 + 32'(4 * (k - 1)));
        end
      end
      total++;
      if (v_log[u][1] !== 1'b0 || v_log[u][2] !== 1'b0 || v_log[u][3] !== 1'b0 || v_log[u][4] !== 1'b1) begin
        bad++;
        $display("FAIL first_retire[%0d]: valid cyc1..4 got %b%b%b%b want 0001",
                 u, v_log[u][1], v_log[u][2], v_log[u][3], v_log[u][4]);
      end
      total++;
      if (retired_count[u] !== 32'd2) begin
        bad++;
        $display("FAIL retired_count[%0d]: got %0d want 2", u, retired_count[u]);
      end
      $display("test_reset inst%0d: first retire cycle 4 checked", u);
    end
  endtask

  task automatic test_dependency();
    int c1 [3] = '{4, 5, 6};
    int c0 [3] = '{4, 7, 10};
    int rds [3] = '{1, 2, 3};
    int dat [3] = '{5, 10, 5};
    int gap [4] = '{5, 6, 8, 9};
    load_nops();
    prog[0] = ins(2, 1, 0, 0, 5);
    prog[1] = ins(0, 2, 1, 1, 0);
    prog[2] = ins(1, 3, 2, 1, 0);
    start();
    run(12);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (v_log[1][c1[j]] !== 1'b1 || r_log[1][c1[j]] !== 5'(rds[j]) || d_log[1][c1[j]] !== 32'(dat[j])) begin
        bad++;
        $display("FAIL fwd_retire cyc%0d: got v=%b rd=%0d data=%0d want 1/%0d/%0d",
                 c1[j], v_log[1][c1[j]], r_log[1][c1[j]], d_log[1][c1[j]], rds[j], dat[j]);
      end
      total++;
      if (v_log[0][c0[j]] !== 1'b1 || r_log[0][c0[j]] !== 5'(rds[j]) || d_log[0][c0[j]] !== 32'(dat[j])) begin
        bad++;
        $display("FAIL stall_retire cyc%0d: got v=%b rd=%0d data=%0d want 1/%0d/%0d",
                 c0[j], v_log[0][c0[j]], r_log[0][c0[j]], d_log[0][c0[j]], rds[j], dat[j]);
      end
      $display("test_dependency: r%0d=%0d fwd@%0d stall@%0d", rds[j], dat[j], c1[j], c0[j]);
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (v_log[0][gap[j]] !== 1'b0) begin
        bad++;
        $display("FAIL stall_bubble cyc%0d: got valid %b want 0", gap[j], v_log[0][gap[j]]);
      end
    end
    total++;
    if (stall_count[1] !== 32'd0) begin
      bad++;
      $display("FAIL fwd_stall_count: got %0d want 0", stall_count[1]);
    end
    total++;
    if (stall_count[0] !== 32'd4) begin
      bad++;
      $display("FAIL nofwd_stall_count: got %0d want 4", stall_count[0]);
    end
  endtask

  task automatic test_branch();
    int cy [5] = '{4, 7, 8, 9, 10};
    int rds [5] = '{0, 1, 0, 2, 3};
    int dat [5] = '{0, 9, 0, 7, 8};
    int wrong;
    load_nops();
    prog[0] = ins(5, 0, 0, 0, 3);
    prog[1] = ins(2, 5, 0, 0, 1);
    prog[2] = ins(2, 6, 0, 0, 2);
    prog[3] = ins(2, 1, 0, 0, 9);
    prog[4] = ins(5, 0, 1, 2, 4);
    prog[5] = ins(2, 2, 0, 0, 7);
    prog[6] = ins(2, 3, 0, 0, 8);
    start();
    run(20);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (a_log[u][4] !== 32'h100C) begin
        bad++;
        $display("FAIL branch_target[%0d]: got %h want 0000100c", u, a_log[u][4]);
      end
      wrong = 0;
      for (int k = 1; k <= 20; k++)
        if (v_log[u][k] === 1'b1 && (r_log[u][k] === 5'd5 || r_log[u][k] === 5'd6)) wrong++;
      total++;
      if (wrong !== 0) begin
        bad++;
        $display("FAIL flushed_retire[%0d]: got %0d shadow retires want 0", u, wrong);
      end
    end
    for (int k = 5; k <= 6; k++) begin
      total++;
      if (v_log[1][k] !== 1'b0) begin
        bad++;
        $display("FAIL branch_penalty cyc%0d: got valid %b want 0", k, v_log[1][k]);
      end
    end
    for (int j = 0; j < 5; j++) begin
      total++;
      if (v_log[1][cy[j]] !== 1'b1 || r_log[1][cy[j]] !== 5'(rds[j]) || d_log[1][cy[j]] !== 32'(dat[j])) begin
        bad++;
        $display("FAIL branch_stream cyc%0d: got v=%b rd=%0d data=%0d want 1/%0d/%0d",
                 cy[j], v_log[1][cy[j]], r_log[1][cy[j]], d_log[1][cy[j]], rds[j], dat[j]);
      end
      $display("test_branch: cyc%0d rd=%0d data=%0d", cy[j], rds[j], dat[j]);
    end
  endtask

  task automatic test_imem_stall();
    load_nops();
    prog[0] = ins(2, 1, 0, 0, 1);
    prog[1] = ins(2, 0, 0, 0, 7);
    prog[2] = ins(0, 4, 0, 0, 0);
    rdy_lo = 2; rdy_hi = 5;
    start();
    run(12);
    for (int u = 0; u < 2; u++) begin
      for (int k = 2; k <= 5; k++) begin
        total++;
        if (a_log[u][k] !== 32'h1004) begin
          bad++;
          $display("FAIL fetch_hold[%0d] cyc%0d: got %h want 00001004", u, k, a_log[u][k]);
        end
      end
      total++;
      if (v_log[u][5] !== 1'b0 || v_log[u][6] !== 1'b0 || v_log[u][7] !== 1'b0 ||
          r_log[u][6] !== 5'd1 || d_log[u][6] !== 32'd1) begin
        bad++;
        $display("FAIL bubbles[%0d]: valid5..7=%b%b%b held rd=%0d data=%0d want 000 1 1",
                 u, v_log[u][5], v_log[u][6], v_log[u][7], r_log[u][6], d_log[u][6]);
      end
      total++;
      if (v_log[u][8] !== 1'b1 || r_log[u][8] !== 5'd0) begin
        bad++;
        $display("FAIL r0_retire[%0d]: got v=%b rd=%0d want 1/0", u, v_log[u][8], r_log[u][8]);
      end
      total++;
      if (v_log[u][9] !== 1'b1 || r_log[u][9] !== 5'd4 || d_log[u][9] !== 32'd0) begin
        bad++;
        $display("FAIL r0_discard[%0d]: got v=%b rd=%0d data=%0d want 1/4/0",
                 u, v_log[u][9], r_log[u][9], d_log[u][9]);
      end
      $display("test_imem_stall inst%0d: ADD r4,r0,r0 -> %0d", u, d_log[u][9]);
    end
    rdy_lo = 0; rdy_hi = 0;
  endtask

  task automatic test_mid_reset();
    load_nops();
    prog[0] = ins(2, 1, 0, 0, 5);
    prog[1] = ins(0, 2, 1, 1, 0);
    start();
    run(5);
    total++;
    if (stall_count[0] !== 32'd2) begin
      bad++;
      $display("FAIL pre_reset_stalls: got %0d want 2", stall_count[0]);
    end
    reset = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (imem_addr[u] !== 32'h1000 || wb_valid[u] !== 1'b0 || wb_rd[u] !== 5'd0 ||
          wb_data[u] !== 32'd0 || retired_count[u] !== 32'd0 || stall_count[u] !== 32'd0) begin
        bad++;
        $display("FAIL async_reset[%0d]: addr=%h v=%b rd=%0d data=%h ret=%0d stl=%0d, want 1000/0/0/0/0/0",
                 u, imem_addr[u], wb_valid[u], wb_rd[u], wb_data[u], retired_count[u], stall_count[u]);
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    run(6);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (v_log[u][1] !== 1'b0 || v_log[u][2] !== 1'b0 || v_log[u][3] !== 1'b0 ||
          a_log[u][1] !== 32'h1000) begin
        bad++;
        $display("FAIL stale_retire[%0d]: valid1..3=%b%b%b addr1=%h want 000 1000",
                 u, v_log[u][1], v_log[u][2], v_log[u][3], a_log[u][1]);
      end
      total++;
      if (v_log[u][4] !== 1'b1 || r_log[u][4] !== 5'd1 || d_log[u][4] !== 32'd5) begin
        bad++;
        $display("FAIL restart_retire[%0d]: got v=%b rd=%0d data=%0d want 1/1/5",
                 u, v_log[u][4], r_log[u][4], d_log[u][4]);
      end
      $display("test_mid_reset inst%0d: restart retire r1=%0d", u, d_log[u][4]);
    end
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_branch();
    test_imem_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath_v2.md
Name: pipelined_datapath_v2

Overview:
- Parametrised successor to the single-issue pipelined datapath.
- Four-stage in-order integer pipeline: Fetch, Decode/RegRead, Execute, Writeback.
- Adds a fetch stall handshake, operand forwarding that can be selected at elaboration, interlocks, and branch resolution with flush.
- Sits between the instruction memory and the testbench/debug retire port. It owns the PC, the 32-entry register file and the ALU.

Parameters:
- DATA_WIDTH, 32, width of registers, ALU and writeback data.
- ADDRESS_SIZE, 32, PC and instruction-address width.
- BOOT_ADDRESS, 32'h1000, PC value after reset.
- FORWARDING, 1, selects hazard handling: 1 = E/W bypass to Decode; 0 = stall-only interlock.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  ADDRESS_SIZE  fetch address (current PC).
- imem_ready  input  1  imem_data is valid this cycle.
- imem_data  input  32  instruction at imem_addr, combinational.
- wb_valid  output  1  an instruction retires this cycle.
- wb_rd  output  5  destination of the retiring instruction.
- wb_data  output  DATA_WIDTH  result of the retiring instruction.
- retired_count  output  32  retired instruction count.
- stall_count  output  32  cycles in which Decode was held by an interlock.

Behaviour:
- Encoding:
  - op[31:28], rd[27:23], rs1[22:18], rs2[17:13], imm[12:0] (sign-extended to DATA_WIDTH).
  - Opcodes: 0 ADD, 1 SUB, 2 ADDI (rs1+imm), 3 AND, 4 OR, 5 BEQ (no write). Any other opcode is a NOP (no write, still retires).
- Arithmetic is modulo 2^DATA_WIDTH.
- Register r0 reads as 0. Writes to r0 retire (wb_valid=1) but are discarded.
- Reset (asserted low, async):
  - pc=BOOT_ADDRESS; all stage valid bits=0; register file=0.
  - wb_valid=0, wb_rd=0, wb_data=0, retired_count=0, stall_count=0.
  - Reset mid-operation discards all in-flight instructions; nothing retires.
- Fetch:
  - imem_addr=pc.
  - If imem_ready=1 and Decode is not stalled: latch imem_data into F/D with valid=1, pc+=4.
  - If imem_ready=0: pc holds and a bubble (valid=0) enters F/D.
- Decode reads the register file. The regfile has no write-through: a write at the end of cycle n is visible to reads in cycle n+1.
- Latency: fetched in cycle n → Execute in n+2 → wb_valid in n+3. Register file is written at the end of n+3.
- FORWARDING=1:
  - Decode operand priority is E result (rd match, write-enabled, valid), then W result, then register file.
  - Zero dependency stalls.
- FORWARDING=0:
  - Decode stalls while any source rs≠0 matches a write-enabled valid rd in E or W.
  - During a stall: F/D and pc hold; a bubble is inserted into E; stall_count increments.
  - A back-to-back dependency costs 2 stall cycles.
- Branch (BEQ):
  - Resolved in Execute using final (forwarded) operands.
  - Taken: target = branch_pc + (sext(imm)<<2); pc←target next cycle; F/D and D/E are invalidated (2-cycle penalty).
  - Not taken: no penalty.
  - If a stall and a taken branch occur in the same cycle, the flush wins.
- Retire: wb_valid=1 for every valid instruction leaving W, and retired_count increments. wb_rd and wb_data hold the last retired values when wb_valid=0.
- Counters wrap at 2^32.

Test Plan:
- Reset release with imem_ready=1 and NOPs → imem_addr 0x1000, 0x1004, 0x1008 on consecutive cycles; first wb_valid on the 4th cycle after release.
- FORWARDING=1: ADDI r1,r0,5; ADD r2,r1,r1; SUB r3,r2,r1 back-to-back → wb (1,5), (2,10), (3,5) on consecutive cycles; stall_count=0.
- FORWARDING=0, same program → r2 retires 3 cycles after r1, r3 retires 3 cycles after r2; stall_count=4.
- BEQ r0,r0,imm=3 at 0x1000 → next fetch 0x100C; instructions at 0x1004/0x1008 never retire; a BEQ with r1≠r2 causes no flush.
- imem_ready=0 for 3 cycles mid-stream → imem_addr held, 3 bubbles, no extra wb_valid; then ADDI r0,r0,7 retires with wb_rd=0 and a following ADD r4,r0,r0 writes 0.
- reset asserted low while 3 instructions are in flight → all outputs and counters 0 immediately; after release, execution restarts at 0x1000 with no stale retire.
